tdc_ctrl: RTL and testbench

Measurement controller that drives the `start` input of the inverter-chain TDC delay line and consumes its captured thermometer code (`time_count`). The TDC line latches on the falling edge of `start`. This block launches `start` pulses, waits for the latched code to settle, and converts each code to a binary edge position. It averages 2^LOG2_SAMPLES samples and presents the result through a valid/ready handshake. It sits directly between the system-side request logic and the delay line.

---
 rtl/tdc_pkg.sv | 13 +
 rtl/tdc_therm2bin.sv | 28 ++
 rtl/tdc_ctrl.sv | 82 ++++++++
 tb/tb_tdc_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// tdc_pkg: shared state type, width helper and timing constants for the TDC controller.
package tdc_pkg;
  typedef enum logic [2:0] {IDLE, HIGH, SETTLE, ACC, LOW, DONE} tdc_state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  localparam int N_DELAY_DEF = 32;
  localparam int RW_DEF = clog2(N_DELAY_DEF + 1);
  localparam int SETTLE_CYCLES = 2;
endpackage

// File: rtl/tdc_therm2bin.sv
// tdc_therm2bin: thermometer code to edge position (index of first zero).
// Define TDC_BUBBLE_FIX_EN to add a 3-tap majority bubble filter before decode.
module tdc_therm2bin
  import tdc_pkg::*;
#(
  parameter int N_DELAY = 32,
  localparam int RW = clog2(N_DELAY + 1)
) (
  input  logic [N_DELAY-1:0] code,
  output logic [RW-1:0]      pos
);
  logic [N_DELAY-1:0] filt;
`ifdef TDC_BUBBLE_FIX_EN
  logic [N_DELAY+1:0] ext;
  assign ext = {1'b0, code, 1'b1};
  for (genvar i = 0; i < N_DELAY; i++) begin : g_maj
    assign filt[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
  end
`else
  assign filt = code;
`endif
  // Scan from the top so the lowest zero wins.
  always_comb begin
    pos = RW'(N_DELAY);
    for (int i = N_DELAY - 1; i >= 0; i--)
      if (!filt[i]) pos = RW'(i);
  end
endmodule

// File: rtl/tdc_ctrl.sv
// tdc_ctrl: launches TDC start pulses, decodes and averages 2^LOG2_SAMPLES codes, valid/ready result.
module tdc_ctrl
  import tdc_pkg::*;
#(
  parameter int N_DELAY = 32,
  parameter int HOLD_CYCLES = 4,
  parameter int LOG2_SAMPLES = 3,
  localparam int RW = clog2(N_DELAY + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               meas_req,
  output logic               meas_busy,
  output logic               tdc_start,
  input  logic [N_DELAY-1:0] tdc_code,
  output logic [RW-1:0]      result,
  output logic               result_ovf,
  output logic               result_valid,
  input  logic               result_ready
);
  localparam int AW = RW + LOG2_SAMPLES;
  localparam int CW = LOG2_SAMPLES + 1;
  localparam int S = 1 << LOG2_SAMPLES;
  tdc_state_t state, state_n;
  logic [7:0] tmr;
  logic [CW-1:0] cnt;
  logic [AW-1:0] acc, acc_n;
  logic ovf, ovf_n, tmr_end, last;
  logic [RW-1:0] pos;
  tdc_therm2bin #(.N_DELAY(N_DELAY)) u_dec (.code(tdc_code), .pos(pos));
  assign tmr_end = tmr == ((state == HIGH || state == LOW) ? 8'(HOLD_CYCLES - 1) : 8'(SETTLE_CYCLES - 1));
  assign last = cnt == CW'(S - 1);
  assign acc_n = acc + AW'(pos);
  assign ovf_n = ovf | (&tdc_code);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = meas_req ? HIGH : IDLE;
      HIGH:    state_n = tmr_end ? SETTLE : HIGH;
      SETTLE:  state_n = tmr_end ? ACC : SETTLE;
      ACC:     state_n = last ? DONE : LOW;
      LOW:     state_n = tmr_end ? HIGH : LOW;
      DONE:    state_n = result_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they leave flops directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tmr <= '0;
      cnt <= '0;
      acc <= '0;
      ovf <= 1'b0;
      tdc_start <= 1'b0;
      meas_busy <= 1'b0;
      result_valid <= 1'b0;
      result <= '0;
      result_ovf <= 1'b0;
    end else begin
      state <= state_n;
      tmr <= (state_n != state) ? '0 : tmr + 8'd1;
      tdc_start <= state_n == HIGH;
      meas_busy <= state_n != IDLE;
      result_valid <= state_n == DONE;
      if (state == IDLE && meas_req) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end
      if (state == ACC) begin
        acc <= acc_n;
        cnt <= cnt + CW'(1);
        ovf <= ovf_n;
      end
      if (state == ACC && last) begin
        result <= RW'(acc_n >> LOG2_SAMPLES);
        result_ovf <= ovf_n;
      end
    end
  end
endmodule

// File: tb/tb_tdc_ctrl.sv
// tb_tdc_ctrl: directed bench with a timeline/average model checked every cycle.
module tb_tdc_ctrl;
  localparam int H = 4;
  localparam int PER = 2 * H + 3;
  localparam int LAT = 8 * (H + 3) + 7 * H;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic meas_req = 1'b0;
  logic result_ready = 1'b0;
  logic [31:0] tdc_code = '0;
  logic meas_busy, tdc_start, result_ovf, result_valid;
  logic [5:0] result;
  logic [31:0] codes [8];
  int k = -1;
  int checks = 0;
  int errors = 0;
  int lat;
  logic [5:0] got_res;
  logic got_ovf;
  tdc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .meas_req(meas_req), .meas_busy(meas_busy),
    .tdc_start(tdc_start), .tdc_code(tdc_code), .result(result),
    .result_ovf(result_ovf), .result_valid(result_valid), .result_ready(result_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int pos_of(input logic [31:0] c);
    logic [31:0] f;
    f = c;
`ifdef TDC_BUBBLE_FIX_EN
    begin
      logic [33:0] e;
      e = {1'b0, c, 1'b1};
      for (int i = 0; i < 32; i++) f[i] = (int'(e[i]) + int'(e[i+1]) + int'(e[i+2])) >= 2;
    end
`endif
    for (int i = 0; i < 32; i++) if (!f[i]) return i;
    return 32;
  endfunction
  function automatic int exp_result();
    int s;
    s = 0;
    for (int j = 0; j < 8; j++) s += pos_of(codes[j]);
    return s >> 3;
  endfunction
  function automatic logic exp_ovf();
    logic o;
    o = 1'b0;
    for (int j = 0; j < 8; j++) o |= (codes[j] == 32'hFFFF_FFFF);
    return o;
  endfunction
  // k counts cycles since the launching edge; LAT means the result is being offered.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k = -1;
    else if (k < 0) begin
      if (meas_req) k = 0;
    end else if (k < LAT) k++;
    else if (result_ready) k = -1;
  end
  always @(negedge clk) tdc_code = (k >= 0 && k < LAT) ? codes[k / PER] : 32'h0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk(tdc_start, (k >= 0 && k < LAT && (k % PER) < H), "tdc_start");
      chk(meas_busy, k >= 0, "meas_busy");
      chk(result_valid, k == LAT, "result_valid");
      if (k == LAT) begin
        chk(result, exp_result(), "result");
        chk(result_ovf, exp_ovf(), "result_ovf");
      end
    end
  end
  task automatic run(input int wait_rdy, output int l, output logic [5:0] r, output logic o);
    int n;
    @(negedge clk) meas_req = 1'b1;
    @(negedge clk) meas_req = 1'b0;
    n = 1;
    while (!result_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(result_valid, 1, "valid_timeout");
    l = n - 1;
    r = result;
    o = result_ovf;
    for (int i = 0; i < wait_rdy; i++) begin
      meas_req = (i == 5);
      @(negedge clk);
    end
    meas_req = 1'b0;
    if (wait_rdy > 0) chk(result, r, "result_held");
    result_ready = 1'b1;
    @(negedge clk) result_ready = 1'b0;
    chk(result_valid, 0, "valid_drop");
    chk(meas_busy, 0, "idle_after_ack");
  endtask
  task automatic fill(input logic [31:0] a, input logic [31:0] b);
    for (int j = 0; j < 8; j++) codes[j] = j[0] ? b : a;
  endtask
  initial begin
    int n;
    fill(32'hFF, 32'hFF);
    #12;
    chk(tdc_start, 0, "rst_start");
    chk(meas_busy, 0, "rst_busy");
    chk(result_valid, 0, "rst_valid");
    chk(result, 0, "rst_result");
    chk(result_ovf, 0, "rst_ovf");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run(0, lat, got_res, got_ovf);
    chk(lat, 84, "latency");
    chk(got_res, 8, "avg_ff");
    chk(got_ovf, 0, "ovf_ff");
    fill(32'h3FF, 32'h1FFF);
    run(0, lat, got_res, got_ovf);
    chk(got_res, 11, "avg_alt");
    chk(got_ovf, 0, "ovf_alt");
    fill(32'hF, 32'hF);
    codes[3] = 32'hFFFF_FFFF;
    run(0, lat, got_res, got_ovf);
    chk(got_res, 7, "avg_ovf");
    chk(got_ovf, 1, "ovf_set");
    fill(32'h17, 32'h17);
    run(20, lat, got_res, got_ovf);
`ifdef TDC_BUBBLE_FIX_EN
    chk(got_res, 4, "avg_bubble");
`else
    chk(got_res, 3, "avg_bubble");
`endif
    chk(result_valid, 0, "ignored_req");
    fill(32'hFF, 32'hFF);
    @(negedge clk) meas_req = 1'b1;
    n = 0;
    while (!result_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(result_valid, 1, "b2b_timeout");
    result_ready = 1'b1;
    @(negedge clk) result_ready = 1'b0;
    chk(meas_busy, 0, "b2b_idle");
    @(negedge clk) meas_req = 1'b0;
    chk(meas_busy, 1, "b2b_relaunch");
    chk(tdc_start, 1, "b2b_start");
    n = 0;
    while (!result_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(n, 84, "b2b_latency");
    result_ready = 1'b1;
    @(negedge clk) result_ready = 1'b0;
    codes[0] = 32'h1;
    @(negedge clk) meas_req = 1'b1;
    @(negedge clk) meas_req = 1'b0;
    n = 0;
    while (k < 2 * PER + 1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tdc_start, 1, "third_high");
    #2 rst_n = 1'b0;
    #1;
    chk(tdc_start, 0, "async_drop");
    chk(meas_busy, 0, "async_busy");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk(tdc_start, 0, "post_rst_start");
    chk(meas_busy, 0, "post_rst_busy");
    chk(result_valid, 0, "post_rst_valid");
    chk(result, 0, "post_rst_result");
    chk(result_ovf, 0, "post_rst_ovf");
    repeat (100) @(negedge clk);
    chk(result_valid, 0, "no_partial");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
